fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter SIZE, default 8, data word width; SHALL match the upstream FIFO word width.
REQ-002 Parameter DIVISOR, default 16, clock cycles per serial bit; SHALL be >= 2.
REQ-003 Parameter PARITY_EN, default 0; 1 = one even-parity bit after the data bits.
REQ-004 CLOCK  in  1  system clock; all state changes on the rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 CLEAR_N  in  1  synchronous clear, active-low; aborts any frame in progress.
REQ-007 ENABLE  in  1  permits starting new frames.
REQ-008 F_EMPTY_N  in  1  upstream FIFO not-empty flag.
REQ-009 FIFO_DATA  in  SIZE  upstream FIFO DATA_OUT, valid the cycle after READ.
REQ-010 READ  out  1  pop request to the upstream FIFO, one-cycle pulse.
REQ-011 TX  out  1  serial line; idle high.
REQ-012 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE: if ENABLE=1 and F_EMPTY_N=1, the next state SHALL be REQ; otherwise the FSM stays in IDLE.
REQ-015 REQ: READ SHALL be 1 for exactly this one cycle; the next state SHALL be LOAD.
REQ-016 READ SHALL never be 1 in any state other than REQ, so an empty FIFO is never popped.
REQ-017 LOAD: the shift register SHALL capture FIFO_DATA; the parity bit SHALL be set to the XOR of FIFO_DATA; the bit counter and baud counter SHALL be set to 0; the next state SHALL be START.
REQ-018 START, each DATA bit, PARITY and STOP SHALL each last exactly DIVISOR cycles, timed by the baud counter.
REQ-019 DATA SHALL send SIZE bits, LSB first, shifting right once per bit period.
REQ-020 After the last data bit, the next state SHALL be PARITY if PARITY_EN=1, otherwise STOP.
REQ-021 At the end of STOP, the next state SHALL be REQ if ENABLE=1 and F_EMPTY_N=1, otherwise IDLE; the inter-frame gap is therefore 2 cycles of TX=1 (REQ, LOAD).
REQ-022 TX SHALL be registered, with these values:
- 1 in IDLE, REQ, LOAD and STOP;
- 0 in START;
- the shift-register LSB in DATA;
- the parity bit in PARITY.
REQ-023 TX SHALL be glitch-free.
REQ-024 Deasserting ENABLE mid-frame SHALL NOT abort the frame; the block SHALL finish the frame, then go to IDLE.
REQ-025 A change of F_EMPTY_N after REQ SHALL NOT affect the frame in progress.
REQ-026 CLEAR_N=0 at any edge SHALL, at that edge:
- set the state to IDLE;
- set TX to 1;
- set READ to 0;
- set the counters and the shift register to 0.
Any word already popped is discarded.
REQ-027 CLEAR_N SHALL take priority over every FSM transition.
REQ-028 The baud counter width SHALL be $clog2(DIVISOR); the bit counter width SHALL be $clog2(SIZE+1).

Reset
REQ-029 RESET_N=0 SHALL immediately, without waiting for a clock edge:
- set the state to IDLE;
- set TX to 1;
- set READ and BUSY to 0;
- set the shift register, parity bit and both counters to 0.
REQ-030 After RESET_N rises, the first possible READ SHALL occur no earlier than the second rising edge.

Structure
REQ-031 The FSM state enum (tx_state_t) and the TX idle level constant SHALL live in a shared package, uart_pkg.
REQ-032 Baud timing SHALL be a separate sub-module, baud_gen, with these properties:
- parameter DIVISOR;
- inputs CLOCK, RESET_N, CLEAR_N, RUN;
- output TICK, high in the last cycle of each bit period.

Verification
REQ-033 SIZE=8, DIVISOR=4, PARITY_EN=0; FIFO holds 8'hA5; ENABLE=1. Expected:
- one READ pulse;
- 2 cycles later, TX = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles;
- BUSY high for 42 cycles, then IDLE.
REQ-034 Same setup with PARITY_EN=1 and data 8'h07. Expected: the parity bit after the data bits is 1, and the frame is 44 cycles long.
REQ-035 FIFO holds 8'h01, 8'h80; ENABLE held high. Expected:
- the second READ occurs the cycle after the last STOP cycle;
- exactly 2 idle-high cycles between the two frames;
- no third READ.
REQ-036 F_EMPTY_N=0 with ENABLE=1 for 100 cycles. Expected: READ never asserted, TX=1 throughout, BUSY=0.
REQ-037 CLEAR_N pulsed low during the 3rd data bit. Expected:
- TX=1 and state IDLE at that edge;
- the next frame starts with a fresh READ;
- no partial bits are resent.
REQ-038 RESET_N asserted mid-START bit, between clock edges. Expected: TX goes to 1 without waiting for a clock edge, READ=0, and BUSY=0 until a new request.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_t : transmitter FSM state encoding
//   TX_IDLE    : level driven on the serial line when no bit is being sent
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Pop handshake between an upstream FIFO and the UART transmitter.
//   F_EMPTY_N : FIFO holds at least one word
//   FIFO_DATA : FIFO read data, valid the cycle after READ
//   READ      : one-cycle pop request
// Modports:
//   master : the transmitter (issues READ, consumes data)
//   slave  : the FIFO (answers READ with data)
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int SIZE = 8
);

  logic            F_EMPTY_N;
  logic [SIZE-1:0] FIFO_DATA;
  logic            READ;

  modport master (
    input  F_EMPTY_N,
    input  FIFO_DATA,
    output READ
  );

  modport slave (
    output F_EMPTY_N,
    output FIFO_DATA,
    input  READ
  );

endinterface

// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Bit-period timer. Counts 0..DIVISOR-1 while RUN is high and raises TICK in
// the last cycle of each period. Held at zero while RUN is low, so each new
// frame starts with a full-length first bit.
// Ports:
//   CLOCK   in  system clock
//   RESET_N in  asynchronous active-low reset
//   CLEAR_N in  synchronous active-low clear
//   RUN     in  count enable (a bit is on the line)
//   TICK    out high in the final cycle of a bit period
// DIVISOR must be >= 2.
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int DIVISOR = 16
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic CLEAR_N,
  input  logic RUN,
  output logic TICK
);

  localparam int            CW   = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)                            count <= '0;
    else if (!CLEAR_N || !RUN || count == LAST) count <= '0;
    else                                     count <= count + CW'(1);
  end

  assign TICK = RUN && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops words from an upstream FIFO and sends each as an asynchronous serial
// frame: start bit, SIZE data bits LSB first, optional even parity, stop bit.
// Ports:
//   CLOCK   in  system clock
//   RESET_N in  asynchronous active-low reset
//   CLEAR_N in  synchronous active-low clear, aborts any frame in progress
//   ENABLE  in  allows new frames to start (never aborts a running one)
//   fifo    --  FIFO pop handshake (fifo_uart_tx_if.master)
//   TX      out registered serial line, idle high
//   BUSY    out high whenever the FSM is not IDLE
// Parameters: SIZE data width, DIVISOR clocks per bit (>= 2),
//             PARITY_EN 1 = append even-parity bit.
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int DIVISOR   = 16,
  parameter int PARITY_EN = 0
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  CLEAR_N,
  input  logic                  ENABLE,
  fifo_uart_tx_if.master        fifo,
  output logic                  TX,
  output logic                  BUSY
);

  localparam int            BW       = $clog2(SIZE + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  tx_state_t       state, state_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [BW-1:0]   bit_cnt, bit_cnt_d;
  logic            tx_d;
  logic            armed;
  logic            run, tick, start_ok;

  assign run      = state inside {START, DATA, PARITY, STOP};
  assign start_ok = ENABLE && fifo.F_EMPTY_N;
  assign BUSY     = (state != IDLE);

  baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .CLEAR_N (CLEAR_N),
    .RUN     (run),
    .TICK    (tick)
  );

  // Next-state, datapath and next-TX decode. TX is computed from the next
  // state so the registered line changes on the same edge as the state.
  always_comb begin
    // NOTE: every output gets a default first; no path can leave one
    // unassigned, so no latch is inferred.
    state_d   = state;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt;

    case (state)
      IDLE:   if (armed && start_ok) state_d = REQ;
      REQ:    state_d = LOAD;
      LOAD: begin
        shift_d   = fifo.FIFO_DATA;
        parity_d  = ^fifo.FIFO_DATA;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = start_ok ? REQ : IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      TX        <= TX_IDLE;
      fifo.READ <= 1'b0;
    end else if (!CLEAR_N) begin
      state     <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      TX        <= TX_IDLE;
      fifo.READ <= 1'b0;
    end else begin
      state     <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt   <= bit_cnt_d;
      TX        <= tx_d;
      fifo.READ <= (state_d == REQ);
    end
  end

  // Blocks a start on the first edge after reset release, so the earliest
  // pop request is registered on the second rising edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) armed <= 1'b0;
    else          armed <= 1'b1;
  end

endmodule
